// File: rtl/inst_fetch_stage.sv
// IF stage: fetch PC, synchronous inst RAM read strobe, and
// next-PC prediction from a direct-mapped BTB with 2-bit counters.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BTB_IDX_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IPD_allow_in,
  output logic        IF_to_IPD_valid,
  output logic [95:0] IF_to_IPD_bus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        btb_upd_valid,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken,
  output logic        inst_ram_en,
  output logic [31:0] inst_ram_addr
);

  localparam int N     = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [31:0]          r_fetch_pc;
  logic                 r_if_valid;
  logic [N-1:0]         r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag    [N];
  logic [31:0]          r_btb_target [N];
  logic [1:0]           r_btb_ctr    [N];

  logic [BTB_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [31:0]          w_pred_pc;
  logic                 w_fire;
  logic [31:0]          w_next_pc;

  logic [BTB_IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0]     w_utag;
  logic                 w_uhit;
  logic [1:0]           w_uctr;
  logic [1:0]           w_ctr_inc;
  logic [1:0]           w_ctr_dec;
  logic                 w_unused_bits;

  assign w_idx = r_fetch_pc[BTB_IDX_W+1:2];
  assign w_tag = r_fetch_pc[31:BTB_IDX_W+2];
  assign w_hit = r_btb_valid[w_idx]
              && (r_btb_tag[w_idx] == w_tag);

  assign w_pred_pc = (w_hit && r_btb_ctr[w_idx][1])
                   ? r_btb_target[w_idx]
                   : r_fetch_pc + 32'd4;

  assign w_fire = r_if_valid & IPD_allow_in
                & ~redirect_valid;

  assign IF_to_IPD_valid = r_if_valid & ~redirect_valid;
  assign IF_to_IPD_bus   = {w_pred_pc, r_fetch_pc, 32'b0};
  assign inst_ram_en     = w_fire;
  assign inst_ram_addr   = r_fetch_pc;

  always_comb begin
    w_next_pc = r_fetch_pc;
    if (redirect_valid)
      w_next_pc = redirect_pc;
    else if (w_fire)
      w_next_pc = w_pred_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_if_valid <= 1'b0;
    end else begin
      r_fetch_pc <= w_next_pc;
      r_if_valid <= 1'b1;
    end
  end

  assign w_uidx = btb_upd_pc[BTB_IDX_W+1:2];
  assign w_utag = btb_upd_pc[31:BTB_IDX_W+2];
  assign w_uhit = r_btb_valid[w_uidx]
               && (r_btb_tag[w_uidx] == w_utag);
  assign w_uctr = r_btb_ctr[w_uidx];

  assign w_ctr_inc = (w_uctr == 2'b11) ? 2'b11
                   : w_uctr + 2'b01;
  assign w_ctr_dec = (w_uctr == 2'b00) ? 2'b00
                   : w_uctr - 2'b01;

  // Byte offset of a branch PC never selects a BTB entry.
  assign w_unused_bits = ^btb_upd_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset)
      r_btb_valid <= '0;
    else if (btb_upd_valid && btb_upd_taken && !w_uhit)
      r_btb_valid[w_uidx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (btb_upd_valid) begin
      if (w_uhit) begin
        if (btb_upd_taken) begin
          r_btb_ctr[w_uidx]    <= w_ctr_inc;
          r_btb_target[w_uidx] <= btb_upd_target;
        end else begin
          r_btb_ctr[w_uidx] <= w_ctr_dec;
        end
      end else if (btb_upd_taken) begin
        r_btb_tag[w_uidx]    <= w_utag;
        r_btb_target[w_uidx] <= btb_upd_target;
        r_btb_ctr[w_uidx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: vector table plus a fetch
// scoreboard fed when a fire is expected, drained on inst_ram_en.
module tb_inst_fetch_stage;

  localparam logic [31:0] B = 32'h1c000000;

  logic        clk;
  logic        reset;
  logic        IPD_allow_in;
  logic        IF_to_IPD_valid;
  logic [95:0] IF_to_IPD_bus;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic        inst_ram_en;
  logic [31:0] inst_ram_addr;

  inst_fetch_stage #(
    .RESET_PC (B),
    .BTB_IDX_W(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IPD_allow_in   (IPD_allow_in),
    .IF_to_IPD_valid(IF_to_IPD_valid),
    .IF_to_IPD_bus  (IF_to_IPD_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .btb_upd_valid  (btb_upd_valid),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target),
    .btb_upd_taken  (btb_upd_taken),
    .inst_ram_en    (inst_ram_en),
    .inst_ram_addr  (inst_ram_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        al;
    logic        rd;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] ut;
    logic        tk;
    logic        ev;
    logic        een;
    logic [31:0] ea;
    logic [31:0] ep;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb [$];
  vec_t        tbl [$];

  function automatic vec_t mk(
    logic rst, logic al, logic rd, logic [31:0] rpc,
    logic uv, logic [31:0] upc, logic [31:0] ut,
    logic tk, logic ev, logic een,
    logic [31:0] ea, logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.al = al; v.rd = rd; v.rpc = rpc;
    v.uv = uv; v.upc = upc; v.ut = ut; v.tk = tk;
    v.ev = ev; v.een = een; v.ea = ea; v.ep = ep;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inst_ram_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb unexpected fire: addr %h expected none",
                 inst_ram_addr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb addr", inst_ram_addr, e[63:32]);
        chk("sb pred", IF_to_IPD_bus[95:64], e[31:0]);
      end
    end
  end

  task automatic apply(vec_t v, string nm);
    @(posedge clk);
    #1;
    reset          = v.rst;
    IPD_allow_in   = v.al;
    redirect_valid = v.rd;
    redirect_pc    = v.rpc;
    btb_upd_valid  = v.uv;
    btb_upd_pc     = v.upc;
    btb_upd_target = v.ut;
    btb_upd_taken  = v.tk;
    if (v.een) sb.push_back({v.ea, v.ep});
    @(negedge clk);
    chk({nm, " valid"}, 32'(IF_to_IPD_valid), 32'(v.ev));
    chk({nm, " en"}, 32'(inst_ram_en), 32'(v.een));
    chk({nm, " addr"}, inst_ram_addr, v.ea);
    chk({nm, " inst_pc"}, IF_to_IPD_bus[63:32], v.ea);
    chk({nm, " pred"}, IF_to_IPD_bus[95:64], v.ep);
  endtask

  initial begin
    reset          = 1'b1;
    IPD_allow_in   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    btb_upd_valid  = 1'b0;
    btb_upd_pc     = '0;
    btb_upd_target = '0;
    btb_upd_taken  = 1'b0;

    // sequential fetch, stall at +8, resume
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 0,0,B,      B+4));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B,      B+4));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+4,    B+8));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,B+8,    B+'hc));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,B+8,    B+'hc));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,B+8,    B+'hc));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+8,    B+'hc));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'hc,  B+'h10));
    // redirect during stall
    tbl.push_back(mk(0,0,1,B+'h100, 0,0,0,0,
                     0,0,B+'h10, B+'h14));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h100, B+'h104));
    // allocate, hit, decay, saturation
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,B+'h40,1,
                     1,0,B+'h104, B+'h108));
    tbl.push_back(mk(0,0,1,B+'h10, 0,0,0,0,
                     0,0,B+'h104, B+'h108));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h10, B+'h40));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h40, B+'h44));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,0,0,
                     1,0,B+'h44, B+'h48));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,0,0,
                     1,0,B+'h44, B+'h48));
    tbl.push_back(mk(0,0,1,B+'h10, 0,0,0,0,
                     0,0,B+'h44, B+'h48));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h10, B+'h14));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,0,0,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,B+'h40,1,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,1,B+'h10, 0,0,0,0,
                     0,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h10, B+'h14));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,B+'h40,1,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,B+'h40,1,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,B+'h80,1,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,0,0, 1,B+'h10,0,0,
                     1,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,0,1,B+'h10, 0,0,0,0,
                     0,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h10, B+'h80));
    // alias replacement at the same index
    tbl.push_back(mk(0,0,0,0, 1,B+'h30,B+'h200,1,
                     1,0,B+'h80, B+'h84));
    tbl.push_back(mk(0,0,1,B+'h10, 0,0,0,0,
                     0,0,B+'h80, B+'h84));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h10, B+'h14));
    tbl.push_back(mk(0,0,1,B+'h30, 0,0,0,0,
                     0,0,B+'h14, B+'h18));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h30, B+'h200));
    // same-cycle lookup and allocate
    tbl.push_back(mk(0,1,0,0, 1,B+'h200,B+'h300,1,
                     1,1,B+'h200, B+'h204));
    tbl.push_back(mk(0,0,1,B+'h200, 0,0,0,0,
                     0,0,B+'h204, B+'h208));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h200, B+'h300));
    // redirect with allow_in high plus update together
    tbl.push_back(mk(0,1,1,B+'h500, 1,B+'h500,B+'h600,1,
                     0,0,B+'h300, B+'h304));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h500, B+'h600));
    // misaligned redirect and address wrap
    tbl.push_back(mk(0,0,1,B+'h402, 0,0,0,0,
                     0,0,B+'h600, B+'h604));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h402, B+'h406));
    tbl.push_back(mk(0,0,1,32'hfffffffc, 0,0,0,0,
                     0,0,B+'h406, B+'h40a));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,
                     1,1,32'hfffffffc, 32'h0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid", 32'(IF_to_IPD_valid), 32'd0);
    chk("rst en", 32'(inst_ram_en), 32'd0);
    chk("rst addr", inst_ram_addr, B);
    chk("rst low", IF_to_IPD_bus[31:0], 32'd0);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // reset together with redirect; BTB must come back empty
    apply(mk(1,1,1,B+'h700, 0,0,0,0, 0,0,32'h0,32'h4),
          "h_rst");
    apply(mk(0,1,0,0, 0,0,0,0, 0,0,B,B+4), "h_rel");
    apply(mk(0,0,1,B+'h500, 0,0,0,0, 0,0,B,B+4), "h_rd");
    apply(mk(0,1,0,0, 0,0,0,0, 1,1,B+'h500,B+'h504),
          "h_clr");

    @(posedge clk);
    #1;
    IPD_allow_in = 1'b0;
    @(negedge clk);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- First pipeline stage (IF) of the in-order LoongArch core; the producer side of the IF→IPD interface.
- Holds the fetch PC and issues synchronous inst RAM reads.
- Produces {pred_PC, inst_PC, 32'b0} plus valid toward IPD, which consumes inst_ram_r_data one cycle after handoff.
- Applies ID-stage redirects and predicts next PC with a small direct-mapped BTB carrying 2-bit counters.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
BTB_IDX_W, 3, BTB index width; BTB_ENTRIES = 2**BTB_IDX_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
IPD_allow_in  in  1  IPD can accept this cycle
IF_to_IPD_valid  out  1  bus holds valid instruction context
IF_to_IPD_bus  out  96  {pred_PC[95:64], inst_PC[63:32], 32'b0[31:0]}
redirect_valid  in  1  ID flush/redirect (br_taken_cancel)
redirect_pc  in  32  correct next PC from ID
btb_upd_valid  in  1  ID resolved a branch/jump this cycle
btb_upd_pc  in  32  PC of the resolved branch
btb_upd_target  in  32  resolved target
btb_upd_taken  in  1  resolved direction
inst_ram_en  out  1  read strobe; RAM output register holds while low
inst_ram_addr  out  32  read address (byte address, word-aligned)

Behaviour:
- State: fetch_pc (32b), if_valid (1b), BTB arrays (valid, tag[31:BTB_IDX_W+2], target[31:0], ctr[1:0]).
- Reset values:
  - fetch_pc = RESET_PC; if_valid = 0; all BTB valid = 0.
  - Outputs: IF_to_IPD_valid = 0, inst_ram_en = 0.
- if_valid becomes 1 on the first edge after reset is released and stays 1 (instruction RAM is always present).
- Lookup is combinational on fetch_pc:
  - idx = fetch_pc[BTB_IDX_W+1:2].
  - hit = valid[idx] & tag match.
  - pred_PC = (hit & ctr[idx][1]) ? target[idx] : fetch_pc + 32'd4. Addition wraps mod 2^32.
- Handoff (fire) = if_valid & IPD_allow_in & ~redirect_valid.
  - IF_to_IPD_valid = if_valid & ~redirect_valid.
  - IF_to_IPD_bus = {pred_PC, fetch_pc, 32'b0}, combinational.
- RAM timing:
  - inst_ram_addr = fetch_pc.
  - inst_ram_en = fire.
  - RAM returns the word one cycle later, aligned with IPD's registered inst_PC.
  - When IPD stalls, en stays 0 so RAM output is held, and IF holds fetch_pc.
- Next fetch_pc, in priority order:
  1. redirect_valid: redirect_pc, regardless of IPD_allow_in. The wrong-path instruction in IF is dropped (no fire).
  2. fire: pred_PC.
  3. Otherwise: hold.
- BTB update, applied at the edge when btb_upd_valid, using uidx/utag from btb_upd_pc:
  - Hit, taken: ctr = sat_inc(ctr); target = btb_upd_target.
  - Hit, not taken: ctr = sat_dec(ctr); target unchanged.
  - Miss, taken: allocate (replace): valid = 1, tag = utag, target = btb_upd_target, ctr = 2'b10.
  - Miss, not taken: no change.
  - Counters saturate at 2'b00 and 2'b11.
- Lookup and update on the same entry in the same cycle: lookup sees pre-update contents; update lands at the edge.
- Redirect and BTB update in the same cycle are independent; both take effect.
- Reset mid-operation: all state returns to reset values on that edge, including a pending redirect. The first post-reset fetch is RESET_PC.
- Misaligned redirect_pc is passed through unchanged; IPD/ID handle any exception.
- Latency: fetch_pc to IPD is 0 cycles (bus is combinational), registered by IPD at the fire edge. Sustained throughput is 1 fetch/cycle when IPD_allow_in = 1.

Test Plan:
1. Reset, then IPD_allow_in = 1 for 4 cycles → inst_ram_addr = 1c000000, 1c000004, 1c000008, 1c00000c on consecutive fires; bus pred_PC = inst_PC + 4; en = 1 each cycle.
2. IPD_allow_in low for 3 cycles at inst_PC 1c000008 → en = 0, addr and bus stable, IF_to_IPD_valid = 1; resumes at 1c000008 then 1c00000c.
3. redirect_valid with redirect_pc = 1c000100 while IPD_allow_in = 0 → IF_to_IPD_valid = 0 that cycle; next cycle addr = 1c000100, valid = 1.
4. Update pc = 1c000010, target = 1c000040, taken → subsequent fetch of 1c000010 gives pred_PC = 1c000040 and next fetch 1c000040. Then two not-taken updates → counter reaches 00, pred_PC = 1c000014.
5. Alias: pc 1c000010 allocated, then taken update at 1c000030 (same idx, different tag) → entry replaced; fetch of 1c000010 misses and predicts +4.
6. Same-cycle update allocating the idx of the current fetch_pc → that cycle predicts +4 (old contents); a refetch of the same PC sees the new target. Also: redirect asserted together with reset → fetch_pc = RESET_PC.
